// File: rtl/scarv_trace_pkg.sv
// Shared types and sizing helpers for the retirement trace buffer.
// Defining SCARV_TRACE_TIMESTAMP_EN adds a 32-bit cycle timestamp to every entry.
package scarv_trace_pkg;

    localparam int TRACE_DEPTH  = 16;
    localparam int TRACE_SEQ_W  = 16;
    localparam int TRACE_DROP_W = 8;

    function automatic int ptr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    localparam int TRACE_PTR_W = ptr_w(TRACE_DEPTH);

    typedef struct packed {
        logic [31:0]            pc;
        logic [31:0]            instr;
        logic [TRACE_SEQ_W-1:0] seq;
`ifdef SCARV_TRACE_TIMESTAMP_EN
        logic [31:0]            ts;
`endif
    } trace_entry_t;

endpackage

// File: rtl/scarv_trace_fifo.sv
// DEPTH x trace_entry_t circular FIFO; a push into a full FIFO only lands when a pop frees a slot.
// Flush clears pointers and level, and storage is never reset.
module scarv_trace_fifo
    import scarv_trace_pkg::*;
#(
    parameter  int DEPTH = TRACE_DEPTH,
    localparam int PTR_W = ptr_w(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               push,
    input  logic               pop,
    input  trace_entry_t       wdata,
    output trace_entry_t       rdata,
    output logic               full,
    output logic               empty,
    output logic [PTR_W:0]     level
);

    trace_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // A flushed cycle discards the offered entry, so the write is gated too.
    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/scarv_trace_buffer.sv
// Retirement trace buffer: tags each retired instruction with a sequence number, counts drops on overflow.
// Optional SCARV_TRACE_TIMESTAMP_EN stores a free-running cycle count per entry on trace_ts_o.
module scarv_trace_buffer
    import scarv_trace_pkg::*;
#(
    parameter  int DEPTH  = TRACE_DEPTH,
    parameter  int SEQ_W  = TRACE_SEQ_W,
    parameter  int DROP_W = TRACE_DROP_W,
    localparam int PTR_W  = ptr_w(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              trs_valid_i,
    input  logic [31:0]       trs_pc_i,
    input  logic [31:0]       trs_instr_i,
    output logic              trace_valid_o,
    input  logic              trace_ready_i,
    output logic [31:0]       trace_pc_o,
    output logic [31:0]       trace_instr_o,
    output logic [SEQ_W-1:0]  trace_seq_o,
    output logic [31:0]       trace_ts_o,
    output logic [PTR_W:0]    level_o,
    output logic              overflow_o,
    output logic [DROP_W-1:0] drop_cnt_o
);

    logic [SEQ_W-1:0]  seq_q;
    logic [DROP_W-1:0] drop_cnt_q;
    logic              overflow_q;
    logic              full;
    logic              empty;
    logic              pop;
    logic              drop;
    trace_entry_t      wentry;
    trace_entry_t      head;

    assign trace_valid_o = !empty;
    assign pop           = trace_valid_o && trace_ready_i;
    assign drop          = trs_valid_i && full && !pop;

`ifdef SCARV_TRACE_TIMESTAMP_EN
    logic [31:0] cycle_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) cycle_q <= '0;
        else                  cycle_q <= cycle_q + 32'd1;
    end
`endif

    // The stored seq field is TRACE_SEQ_W wide; SEQ_W should not exceed it.
    always_comb begin
        wentry       = '0;
        wentry.pc    = trs_pc_i;
        wentry.instr = trs_instr_i;
        wentry.seq   = TRACE_SEQ_W'(seq_q);
`ifdef SCARV_TRACE_TIMESTAMP_EN
        wentry.ts    = cycle_q;
`endif
    end

    scarv_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .flush (clear_i),
        .push  (trs_valid_i),
        .pop   (pop),
        .wdata (wentry),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            seq_q      <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (trs_valid_i) seq_q <= seq_q + 1'b1;
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
            end
        end
    end

    // Head data is forced to zero while empty so stale storage never leaks out.
    assign trace_pc_o    = trace_valid_o ? head.pc    : '0;
    assign trace_instr_o = trace_valid_o ? head.instr : '0;
    assign trace_seq_o   = trace_valid_o ? SEQ_W'(head.seq) : '0;
`ifdef SCARV_TRACE_TIMESTAMP_EN
    assign trace_ts_o    = trace_valid_o ? head.ts    : '0;
`else
    assign trace_ts_o    = '0;
`endif

    assign overflow_o = overflow_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule
